// File: rtl/dram_pkg.sv
// dram_pkg: shared types for the DRAM arbiter slice.
// State encoding, 68030 SIZ codes and default address width.
package dram_pkg;

  localparam int DRAM_ADDR_W = 28;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_LATCH,
    ARB_STROBE,
    ARB_RELEASE
  } arb_state_e;

  typedef enum logic [1:0] {
    SIZ_LONG  = 2'b00,
    SIZ_BYTE  = 2'b01,
    SIZ_WORD  = 2'b10,
    SIZ_3BYTE = 2'b11
  } siz_e;

endpackage

// File: rtl/dram_arb_starve.sv
// dram_arb_starve: saturating DMA wait counter.
// Raises override once the DMA has waited MAX_WAIT edges.
module dram_arb_starve #(
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic dma_wait,
  input  logic dma_grant,
  output logic override
);

  localparam logic [WAIT_W-1:0] CNT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (dma_grant) begin
      cnt_q <= '0;
    end else if (dma_wait && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign override = (cnt_q == CNT_MAX);

endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the DRAM controller between CPU and DMA.
// Optional DMA starvation override: define DRAM_ARB_STARVE_EN.
module dram_arbiter
  import dram_pkg::*;
#(
  parameter int ADDR_W   = DRAM_ADDR_W,
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_req,
  input  logic              cpu_rnw,
  input  logic [1:0]        cpu_siz,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_rnw,
  input  logic [1:0]        dma_siz,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic              dma_ack,
  output logic              mem_nAS,
  output logic              mem_nRAMSEL,
  output logic              mem_rnw,
  output logic [1:0]        mem_siz,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_dsack,
  output logic              grant_dma,
  output logic              busy
);

  if (MAX_WAIT < 1 || MAX_WAIT >= (1 << WAIT_W)) begin : g_cfg_err
    $error("dram_arbiter: WAIT_W too narrow for MAX_WAIT");
  end

  arb_state_e state_q, state_d;
  logic grant_now;
  logic pick_dma;
  logic dma_ovr;
  logic strobe_on;
  logic strobe_off;
  logic ack_fire;

  assign busy = (state_q != ARB_IDLE);

`ifdef DRAM_ARB_STARVE_EN
  logic dma_wait;
  logic dma_grant;

  assign dma_wait  = dma_req && !(busy && grant_dma);
  assign dma_grant = grant_now && pick_dma;

  dram_arb_starve #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_starve (
    .CLK       (CLK),
    .RST       (RST),
    .dma_wait  (dma_wait),
    .dma_grant (dma_grant),
    .override  (dma_ovr)
  );
`else
  assign dma_ovr = 1'b0;
`endif

  // CPU wins ties unless the starvation override is up
  assign pick_dma = dma_req && (!cpu_req || dma_ovr);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_now  = 1'b0;
    strobe_on  = 1'b0;
    strobe_off = 1'b0;
    ack_fire   = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (cpu_req || dma_req) begin
          grant_now = 1'b1;
          state_d   = ARB_LATCH;
        end
      end
      ARB_LATCH: begin
        strobe_on = 1'b1;
        state_d   = ARB_STROBE;
      end
      ARB_STROBE: begin
        if (mem_dsack) begin
          strobe_off = 1'b1;
          ack_fire   = 1'b1;
          state_d    = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        if (!mem_dsack) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_nAS     <= 1'b1;
      mem_nRAMSEL <= 1'b1;
      mem_rnw     <= 1'b1;
      mem_siz     <= SIZ_LONG;
      mem_addr    <= '0;
      grant_dma   <= 1'b0;
      cpu_ack     <= 1'b0;
      dma_ack     <= 1'b0;
    end else begin
      cpu_ack <= ack_fire && !grant_dma;
      dma_ack <= ack_fire && grant_dma;
      if (grant_now) begin
        grant_dma <= pick_dma;
        mem_rnw   <= pick_dma ? dma_rnw : cpu_rnw;
        mem_siz   <= pick_dma ? dma_siz : cpu_siz;
        mem_addr  <= pick_dma ? dma_addr : cpu_addr;
      end
      if (strobe_on) begin
        mem_nAS     <= 1'b0;
        mem_nRAMSEL <= 1'b0;
      end else if (strobe_off) begin
        mem_nAS     <= 1'b1;
        mem_nRAMSEL <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed bench for dram_arbiter.
// Includes a small DSACK responder standing in for the controller.
module tb_dram_arbiter;

  localparam int AW = 28;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          cpu_req = 1'b0;
  logic          cpu_rnw = 1'b1;
  logic [1:0]    cpu_siz = 2'b00;
  logic [AW-1:0] cpu_addr = '0;
  logic          cpu_ack;
  logic          dma_req = 1'b0;
  logic          dma_rnw = 1'b1;
  logic [1:0]    dma_siz = 2'b00;
  logic [AW-1:0] dma_addr = '0;
  logic          dma_ack;
  logic          mem_nAS;
  logic          mem_nRAMSEL;
  logic          mem_rnw;
  logic [1:0]    mem_siz;
  logic [AW-1:0] mem_addr;
  logic          mem_dsack = 1'b0;
  logic          grant_dma;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  int dsack_delay  = 1;
  int release_hold = 0;
  int scnt = 0;
  int rcnt = 0;

  int n_cpu_ack = 0;
  int n_dma_ack = 0;
  bit cpu_rerq = 1'b0;
  bit cpu_pend = 1'b0;
  logic busy_q = 1'b0;
  logic gr_dma[$];
  logic [AW-1:0] gr_addr[$];

  dram_arbiter #(.ADDR_W(AW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .cpu_req     (cpu_req),
    .cpu_rnw     (cpu_rnw),
    .cpu_siz     (cpu_siz),
    .cpu_addr    (cpu_addr),
    .cpu_ack     (cpu_ack),
    .dma_req     (dma_req),
    .dma_rnw     (dma_rnw),
    .dma_siz     (dma_siz),
    .dma_addr    (dma_addr),
    .dma_ack     (dma_ack),
    .mem_nAS     (mem_nAS),
    .mem_nRAMSEL (mem_nRAMSEL),
    .mem_rnw     (mem_rnw),
    .mem_siz     (mem_siz),
    .mem_addr    (mem_addr),
    .mem_dsack   (mem_dsack),
    .grant_dma   (grant_dma),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  // controller stand-in: DSACK after dsack_delay strobe cycles,
  // held release_hold extra cycles after strobes rise
  always @(posedge CLK) begin
    #2;
    if (RST) begin
      scnt = 0;
      rcnt = 0;
      mem_dsack = 1'b0;
    end else if (!mem_nAS) begin
      rcnt = 0;
      scnt++;
      if (scnt >= dsack_delay) mem_dsack = 1'b1;
    end else if (mem_dsack) begin
      rcnt++;
      if (rcnt > release_hold) begin
        mem_dsack = 1'b0;
        scnt = 0;
      end
    end else begin
      scnt = 0;
    end
  end

  task automatic clear_stats();
    n_cpu_ack = 0;
    n_dma_ack = 0;
    cpu_pend = 1'b0;
    busy_q = busy;
    gr_dma.delete();
    gr_addr.delete();
  endtask

  // one cycle: sample at negedge, log grants, requesters drop on ack
  task automatic step();
    @(negedge CLK);
    if (busy && !busy_q) begin
      gr_dma.push_back(grant_dma);
      gr_addr.push_back(mem_addr);
    end
    busy_q = busy;
    if (cpu_ack) begin
      n_cpu_ack++;
      cpu_req = 1'b0;
      cpu_pend = cpu_rerq;
    end else if (cpu_pend) begin
      cpu_req = 1'b1;
      cpu_pend = 1'b0;
    end
    if (dma_ack) begin
      n_dma_ack++;
      dma_req = 1'b0;
    end
  endtask

  function automatic logic [8:0] outv();
    return {mem_nAS, mem_nRAMSEL, mem_rnw, mem_siz,
            cpu_ack, dma_ack, grant_dma, busy};
  endfunction

  task automatic test_reset();
    logic [8:0] v;
    step();
    step();
    v = outv();
    n_cmp++;
    if (v !== 9'b1_1_1_00_0000) begin
      n_bad++;
      $display("FAIL reset_outs got=%b want=%b", v, 9'b111000000);
    end
    n_cmp++;
    if (mem_addr !== '0) begin
      n_bad++;
      $display("FAIL reset_addr got=%h want=0", mem_addr);
    end
    RST = 1'b0;
    step();
    dsack_delay = 100;
    dma_req = 1'b1;
    dma_rnw = 1'b0;
    dma_siz = 2'b01;
    dma_addr = 28'h0ABCDE0;
    for (int i = 0; i < 10 && mem_nAS; i++) step();
    n_cmp++;
    if (mem_nAS !== 1'b0) begin
      n_bad++;
      $display("FAIL strobe_wait got nAS=%b want=0", mem_nAS);
    end
    step();
    step();
    RST = 1'b1;
    #1;
    v = outv();
    n_cmp++;
    if (v !== 9'b1_1_1_00_0000 || mem_addr !== '0) begin
      n_bad++;
      $display("FAIL reset_mid got=%b/%h want=%b/0",
               v, mem_addr, 9'b111000000);
    end
    dma_req = 1'b0;
    step();
    step();
    RST = 1'b0;
    dsack_delay = 1;
    clear_stats();
    cpu_req = 1'b1;
    cpu_rnw = 1'b0;
    cpu_siz = 2'b10;
    cpu_addr = 28'h0005678;
    for (int i = 0; i < 12; i++) step();
    n_cmp++;
    if (n_cpu_ack !== 1 || n_dma_ack !== 0) begin
      n_bad++;
      $display("FAIL post_reset_acks got cpu=%0d dma=%0d want 1/0",
               n_cpu_ack, n_dma_ack);
    end
    n_cmp++;
    if (gr_dma.size() !== 1 ||
        (gr_addr.size() > 0 ? gr_addr[0] : 'x) !== 28'h0005678) begin
      n_bad++;
      $display("FAIL post_reset_grant got n=%0d want 1 @5678",
               gr_dma.size());
    end
  endtask

  task automatic test_lone_cpu();
    logic e_nas, e_ack, e_busy;
    clear_stats();
    dsack_delay = 3;
    release_hold = 0;
    cpu_req = 1'b1;
    cpu_rnw = 1'b1;
    cpu_siz = 2'b00;
    cpu_addr = 28'h0001234;
    for (int n = 1; n <= 7; n++) begin
      step();
      e_nas  = !(n >= 2 && n <= 4);
      e_ack  = (n == 5);
      e_busy = (n <= 5);
      n_cmp++;
      if (mem_nAS !== e_nas || mem_nRAMSEL !== e_nas) begin
        n_bad++;
        $display("FAIL lone_strobe e%0d got=%b%b want=%b",
                 n, mem_nAS, mem_nRAMSEL, e_nas);
      end
      n_cmp++;
      if (cpu_ack !== e_ack || dma_ack !== 1'b0) begin
        n_bad++;
        $display("FAIL lone_ack e%0d got=%b/%b want=%b/0",
                 n, cpu_ack, dma_ack, e_ack);
      end
      n_cmp++;
      if (busy !== e_busy) begin
        n_bad++;
        $display("FAIL lone_busy e%0d got=%b want=%b",
                 n, busy, e_busy);
      end
      n_cmp++;
      if (mem_addr !== 28'h0001234 || mem_rnw !== 1'b1 ||
          mem_siz !== 2'b00 || grant_dma !== 1'b0) begin
        n_bad++;
        $display("FAIL lone_bus e%0d got=%h/%b/%b/%b want 1234/1/00/0",
                 n, mem_addr, mem_rnw, mem_siz, grant_dma);
      end
    end
  endtask

  task automatic test_tie();
    clear_stats();
    dsack_delay = 1;
    cpu_rnw = 1'b1;
    cpu_siz = 2'b10;
    cpu_addr = 28'h0000100;
    dma_rnw = 1'b0;
    dma_siz = 2'b11;
    dma_addr = 28'h0000200;
    cpu_req = 1'b1;
    dma_req = 1'b1;
    for (int i = 0; i < 20; i++) step();
    n_cmp++;
    if (gr_dma.size() !== 2) begin
      n_bad++;
      $display("FAIL tie_ngrant got=%0d want=2", gr_dma.size());
    end
    n_cmp++;
    if ((gr_dma.size() > 0 ? gr_dma[0] : 1'bx) !== 1'b0 ||
        (gr_addr.size() > 0 ? gr_addr[0] : 'x) !== 28'h0000100) begin
      n_bad++;
      $display("FAIL tie_first got not cpu@100 want cpu@100");
    end
    n_cmp++;
    if ((gr_dma.size() > 1 ? gr_dma[1] : 1'bx) !== 1'b1 ||
        (gr_addr.size() > 1 ? gr_addr[1] : 'x) !== 28'h0000200) begin
      n_bad++;
      $display("FAIL tie_second got not dma@200 want dma@200");
    end
    n_cmp++;
    if (n_cpu_ack !== 1 || n_dma_ack !== 1) begin
      n_bad++;
      $display("FAIL tie_acks got cpu=%0d dma=%0d want 1/1",
               n_cpu_ack, n_dma_ack);
    end
    n_cmp++;
    if (busy !== 1'b0 || grant_dma !== 1'b1 || mem_siz !== 2'b11) begin
      n_bad++;
      $display("FAIL tie_hold got busy=%b gd=%b siz=%b want 0/1/11",
               busy, grant_dma, mem_siz);
    end
  endtask

  task automatic test_starvation();
    int ndma;
    clear_stats();
    dsack_delay = 1;
    release_hold = 0;
    cpu_addr = 28'h0000500;
    dma_addr = 28'h0000600;
    cpu_rerq = 1'b1;
    cpu_req = 1'b1;
    dma_req = 1'b1;
`ifdef DRAM_ARB_STARVE_EN
    for (int i = 0; i < 40 && gr_dma.size() < 3; i++) step();
    n_cmp++;
    if (gr_dma.size() < 3) begin
      n_bad++;
      $display("FAIL starve_timeout got=%0d grants want=3",
               gr_dma.size());
    end
    n_cmp++;
    if ((gr_dma.size() > 2 ? {gr_dma[0], gr_dma[1], gr_dma[2]} : 3'bx)
        !== 3'b001) begin
      n_bad++;
      $display("FAIL starve_order got=%0d grants want cpu,cpu,dma",
               gr_dma.size());
    end
    cpu_rerq = 1'b0;
    for (int i = 0; i < 20; i++) step();
`else
    for (int i = 0; i < 30; i++) step();
    ndma = 0;
    foreach (gr_dma[i]) if (gr_dma[i]) ndma++;
    n_cmp++;
    if (ndma !== 0 || gr_dma.size() !== 8) begin
      n_bad++;
      $display("FAIL strict_prio got dma=%0d n=%0d want 0/8",
               ndma, gr_dma.size());
    end
    cpu_rerq = 1'b0;
    for (int i = 0; i < 20; i++) step();
    n_cmp++;
    if ((gr_dma.size() > 8 ? gr_dma[8] : 1'bx) !== 1'b1) begin
      n_bad++;
      $display("FAIL strict_dma_after got n=%0d want dma at 9th",
               gr_dma.size());
    end
`endif
    n_cmp++;
    if (n_dma_ack !== 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL starve_done got dack=%0d busy=%b want 1/0",
               n_dma_ack, busy);
    end
    cpu_pend = 1'b0;
    cpu_req = 1'b0;
  endtask

  task automatic test_abandon();
    clear_stats();
    dsack_delay = 3;
    dma_addr = 28'h0ABC000;
    dma_req = 1'b1;
    for (int i = 0; i < 10 && mem_nAS; i++) step();
    n_cmp++;
    if (mem_nAS !== 1'b0) begin
      n_bad++;
      $display("FAIL abandon_strobe got nAS=%b want=0", mem_nAS);
    end
    dma_req = 1'b0;
    for (int i = 0; i < 15; i++) step();
    n_cmp++;
    if (n_dma_ack !== 1 || gr_dma.size() !== 1) begin
      n_bad++;
      $display("FAIL abandon got dack=%0d grants=%0d want 1/1",
               n_dma_ack, gr_dma.size());
    end
    n_cmp++;
    if (busy !== 1'b0 || grant_dma !== 1'b1 ||
        mem_addr !== 28'h0ABC000) begin
      n_bad++;
      $display("FAIL abandon_hold got busy=%b gd=%b a=%h want 0/1/abc000",
               busy, grant_dma, mem_addr);
    end
  endtask

  task automatic test_slow_release();
    int hold;
    int gstep;
    clear_stats();
    dsack_delay = 1;
    release_hold = 4;
    cpu_addr = 28'h0000300;
    dma_addr = 28'h0000400;
    cpu_req = 1'b1;
    for (int i = 0; i < 10 && n_cpu_ack == 0; i++) step();
    n_cmp++;
    if (n_cpu_ack !== 1) begin
      n_bad++;
      $display("FAIL slow_ack got=%0d want=1", n_cpu_ack);
    end
    dma_req = 1'b1;
    hold = (busy && mem_dsack && mem_nAS) ? 1 : 0;
    gstep = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (busy && mem_dsack && mem_nAS && gr_dma.size() == 1) hold++;
      if (gstep < 0 && gr_dma.size() == 2) gstep = k;
    end
    n_cmp++;
    if (hold !== 4) begin
      n_bad++;
      $display("FAIL slow_hold got=%0d want=4", hold);
    end
    n_cmp++;
    if (gstep !== 6) begin
      n_bad++;
      $display("FAIL slow_grant got=%0d want=6", gstep);
    end
    release_hold = 0;
    for (int i = 0; i < 20; i++) step();
    n_cmp++;
    if (n_dma_ack !== 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL slow_done got dack=%0d busy=%b want 1/0",
               n_dma_ack, busy);
    end
  endtask

  initial begin
    test_reset();
    test_lone_cpu();
    test_tie();
    test_starvation();
    test_abandon();
    test_slow_release();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
